prog_loader: RTL

//  Boot/run sequencer upstream of the processor top level. Accepts a stream of 9-bit machine-code words

---
 rtl/loader_pkg.sv | 28 ++
 rtl/run_timer.sv | 28 ++
 rtl/prog_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared state type, default geometry and parity helper for the program loader.
// LOAD_PARITY_EN widens each load word by one even-parity bit.
package loader_pkg;

    localparam int D_DEFAULT = 12;
    localparam int W_DEFAULT = 9;
    localparam int C_DEFAULT = 16;

`ifdef LOAD_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DONE,
        ERR
    } state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/run_timer.sv
// Saturating run-cycle counter: clear restarts (at 1 when enabled in the same cycle),
// enable counts, freeze holds the value on the cycle the run ends.
module run_timer #(
    parameter int C = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         freeze,
    output logic [C-1:0] count,
    output logic         sat
);

    assign sat = &count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= enable ? C'(1) : '0;
        end else if (enable && !freeze && !sat) begin
            count <= count + C'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot/run sequencer: streams a program into the instruction ROM, releases the core and times
// the run. Define LOAD_PARITY_EN to carry and check an even-parity bit on every load word.
module prog_loader
    import loader_pkg::*;
#(
    parameter int D = D_DEFAULT,
    parameter int W = W_DEFAULT,
    parameter int C = C_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  ld_valid,
    input  logic [W+PAR_BITS-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  im_wr_en,
    output logic [D-1:0]          im_wr_addr,
    output logic [W-1:0]          im_wr_data,
    output logic                  core_reset,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  run_done,
    output logic                  err,
    output logic [D:0]            word_cnt,
    output logic [C-1:0]          cycles
);

    localparam logic [D:0] ROM_WORDS = {1'b1, {D{1'b0}}};

    state_t state_q, state_d;
    logic   beat, par_err, rom_full;
    logic   do_write, wc_clr;
    logic   tmr_clr, tmr_en, tmr_freeze, tmr_sat;

    assign beat     = ld_valid && ld_ready;
    assign rom_full = (word_cnt == ROM_WORDS);

`ifdef LOAD_PARITY_EN
    assign par_err = ld_data[W] != even_parity(32'(ld_data[W-1:0]));
`else
    assign par_err = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        do_write   = 1'b0;
        wc_clr     = 1'b0;
        tmr_clr    = 1'b0;
        tmr_freeze = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    wc_clr  = 1'b1;
                    tmr_clr = 1'b1;
                    if (par_err) begin
                        state_d = ERR;
                    end else begin
                        do_write = 1'b1;
                        state_d  = ld_last ? RUN : LOAD;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    if (par_err) begin
                        state_d = ERR;
                    end else if (rom_full) begin
                        // ROM already full: a closing beat still starts the run but is not written.
                        state_d = ld_last ? RUN : ERR;
                    end else begin
                        do_write = 1'b1;
                        state_d  = ld_last ? RUN : LOAD;
                    end
                end
            end
            RUN: begin
                // Done is checked before the timeout so a coincident done wins.
                if (core_done && cycles > C'(1)) begin
                    state_d    = DONE;
                    tmr_freeze = 1'b1;
                end else if (tmr_sat) begin
                    state_d    = ERR;
                    tmr_freeze = 1'b1;
                end
            end
            DONE, ERR: begin
                if (clr) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counting starts on the edge that enters RUN so the first RUN cycle reads 1.
    assign tmr_en = (state_q == RUN) || (state_d == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ld_ready   <= 1'b0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            run_done   <= 1'b0;
            err        <= 1'b0;
            im_wr_en   <= 1'b0;
            im_wr_addr <= '0;
            im_wr_data <= '0;
            word_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            ld_ready   <= (state_d == IDLE) || (state_d == LOAD);
            core_reset <= (state_d != RUN);
            busy       <= (state_d == LOAD) || (state_d == RUN);
            run_done   <= (state_d == DONE);
            err        <= (state_d == ERR);
            im_wr_en   <= do_write;
            if (do_write) begin
                im_wr_addr <= wc_clr ? '0 : word_cnt[D-1:0];
                im_wr_data <= ld_data[W-1:0];
            end
            if (wc_clr) begin
                word_cnt <= (D+1)'(do_write);
            end else if (do_write) begin
                word_cnt <= word_cnt + (D+1)'(1);
            end
        end
    end

    run_timer #(
        .C(C)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (tmr_clr),
        .enable(tmr_en),
        .freeze(tmr_freeze),
        .count (cycles),
        .sat   (tmr_sat)
    );

endmodule
